// File: rtl/or1k_wb_mem_arbiter_pkg.sv
// Shared types and constants for the OR1K Wishbone memory arbiter.
package or1k_wb_mem_arbiter_pkg;

    // Arbiter FSM: IDLE arbitrates, BUSY holds the grant for one bus cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Wishbone cycle type identifiers.
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Slave response budget, in cycles, after stb is issued.
    localparam int DEFAULT_TIMEOUT = 255;

    // Width of a master index; at least one bit so a single master still works.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/or1k_rr_arbiter.sv
// Combinational rotate-priority encoder: the search starts just after the
// last owner and wraps, so the first requester found gets the one-hot grant.
module or1k_rr_arbiter
    import or1k_wb_mem_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   last_owner,
    output logic [N-1:0]              grant
);

    int   idx;
    logic found;

    // Walk indices last_owner+1 .. last_owner+N (mod N); first request wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_owner) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/or1k_wb_mem_arbiter.sv
// Wishbone arbiter giving NUM_MASTERS masters (0 = debug, 1 = or1k_i,
// 2 = or1k_d) round-robin access to one slave, with a response watchdog.
//
// Handshake: a master owns the bus from grant until it drops cyc. A beat is
// offered while cyc and stb are high and completes in the cycle the slave
// raises exactly one of ack/err/rty; responses reach only the owner, and only
// while its stb is high, so late or stray responses are discarded.
module or1k_wb_mem_arbiter
    import or1k_wb_mem_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_MASTERS-1:0]      m_rty_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic [2:0]                  s_cti_o,
    output logic [1:0]                  s_bte_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output arb_state_t                  state_o
);

    localparam int IW = idx_width(NUM_MASTERS);
    localparam int WW = $clog2(TIMEOUT + 1);

    arb_state_t             state, state_nxt;
    logic [IW-1:0]          owner, owner_nxt;
    logic [WW-1:0]          wdog, wdog_nxt;
    logic [NUM_MASTERS-1:0] rr_grant;
    logic [IW-1:0]          rr_idx;
    logic                   busy, own_cyc, own_stb, any_resp, timeout, beat;

    or1k_rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .req        (m_cyc_i),
        .last_owner (owner),
        .grant      (rr_grant)
    );

    assign busy     = (state == ST_BUSY);
    assign any_resp = s_ack_i | s_err_i | s_rty_i;
    // A real response in the same cycle as the deadline wins over the timeout.
    assign timeout  = busy & own_stb & (wdog == WW'(TIMEOUT)) & ~any_resp;
    assign beat     = busy & own_cyc & own_stb;
    assign s_cyc_o  = busy & own_cyc & ~timeout;
    assign s_stb_o  = s_cyc_o & own_stb;
    assign m_dat_o  = s_dat_i;
    assign state_o  = state;

    // One-hot winner from the priority encoder to an index.
    always_comb begin
        rr_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (rr_grant[i]) rr_idx = IW'(i);
    end

    // Route the owner's request to the slave and the slave's response to the owner.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = CTI_CLASSIC;
        s_bte_o = '0;
        s_we_o  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        grant_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner == IW'(i)) begin
                s_adr_o = m_adr_i[i*AW +: AW];
                s_dat_o = m_dat_i[i*DW +: DW];
                s_sel_o = m_sel_i[i*(DW/8) +: DW/8];
                s_cti_o = m_cti_i[i*3 +: 3];
                s_bte_o = m_bte_i[i*2 +: 2];
                s_we_o  = m_we_i[i];
                own_cyc = m_cyc_i[i];
                own_stb = m_stb_i[i];
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner == IW'(i)) begin
                m_ack_o[i] = beat & s_ack_i;
                m_err_o[i] = (beat & s_err_i) | timeout;
                m_rty_o[i] = beat & s_rty_i;
                grant_o[i] = busy;
            end
        end
    end

    // Next state: grant in IDLE, release on owner cyc drop or watchdog expiry.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        wdog_nxt  = '0;
        case (state)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    state_nxt = ST_BUSY;
                    owner_nxt = rr_idx;
                end
            end
            ST_BUSY: begin
                if (!own_cyc || timeout) state_nxt = ST_IDLE;
                else if (own_stb && !any_resp) wdog_nxt = wdog + WW'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, owner and watchdog registers; reset leaves master 0 first in line.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state <= ST_IDLE;
            owner <= IW'(NUM_MASTERS - 1);
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            wdog  <= wdog_nxt;
        end
    end

endmodule

// File: tb/tb_or1k_wb_mem_arbiter.sv
// Self-checking bench for or1k_wb_mem_arbiter (3 masters, TIMEOUT = 4).
module tb_or1k_wb_mem_arbiter;
    import or1k_wb_mem_arbiter_pkg::*;

    localparam int NM = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NM*32-1:0] m_adr, m_dat;
    logic [NM*4-1:0]  m_sel;
    logic [NM*3-1:0]  m_cti;
    logic [NM*2-1:0]  m_bte;
    logic [NM-1:0]    m_we, m_cyc, m_stb;
    logic [31:0]      m_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [3:0]       s_sel_o;
    logic [2:0]       s_cti_o;
    logic [1:0]       s_bte_o;
    logic             s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
    arb_state_t       state_o;

    or1k_wb_mem_arbiter #(.NUM_MASTERS(NM), .AW(32), .DW(32), .TIMEOUT(4)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cti_i(m_cti),
        .m_bte_i(m_bte), .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_bte_o(s_bte_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o), .state_o(state_o)
    );

    // ---------------- scoreboard ----------------
    logic [NM-1:0] exp_q[$];
    logic [31:0]   adr_q[$];
    int            n_chk = 0;
    int            n_fail = 0;

    function automatic logic [31:0] base_adr(input int m);
        return 32'h1000 * (m + 1);
    endfunction

    function automatic int oh2idx(input logic [NM-1:0] g);
        int r = 0;
        for (int i = 0; i < NM; i++) if (g[i]) r = i;
        return r;
    endfunction

    // ---------------- drivers ----------------
    // Advance to just after the next rising edge; inputs are driven here and
    // outputs are sampled a couple of time units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int m, input bit cyc, input bit stb,
                              input logic [2:0] cti, input logic [31:0] adr);
        m_cyc[m]         = cyc;
        m_stb[m]         = stb;
        m_cti[m*3 +: 3]  = cti;
        m_adr[m*32 +: 32] = adr;
        m_dat[m*32 +: 32] = $urandom;
        m_we[m]          = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_all();
        for (int m = 0; m < NM; m++) set_master(m, 1'b0, 1'b0, CTI_CLASSIC, base_adr(m));
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_all();
        m_sel = '1; m_bte = '0; s_dat_i = 32'hdead_beef;
        rst_n = 1'b0;
        for (int m = 0; m < NM; m++) set_master(m, 1'b1, 1'b1, CTI_CLASSIC, base_adr(m));
        s_ack_i = 1'b1;
        step(); step(); #2;
        n_chk++; if (grant_o !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", grant_o); end
        n_chk++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc_stb: got %b%b want 00", s_cyc_o, s_stb_o); end
        n_chk++; if ({m_ack_o, m_err_o, m_rty_o} !== 9'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 0", {m_ack_o, m_err_o, m_rty_o}); end
        n_chk++; if (state_o !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", state_o); end
        idle_all();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_contest();
        logic [NM-1:0] exp_g;
        int o;
        for (int m = 0; m < NM; m++) set_master(m, 1'b1, 1'b1, CTI_CLASSIC, base_adr(m));
        exp_q.push_back(3'b001); exp_q.push_back(3'b010);
        exp_q.push_back(3'b100); exp_q.push_back(3'b001);
        for (int g = 0; g < 4; g++) begin
            step(); #2;
            exp_g = exp_q.pop_front();
            o = oh2idx(exp_g);
            n_chk++; if (grant_o !== exp_g) begin n_fail++; $display("FAIL contest_grant%0d: got %b want %b", g, grant_o, exp_g); end
            n_chk++; if (s_adr_o !== base_adr(o)) begin n_fail++; $display("FAIL contest_adr%0d: got %h want %h", g, s_adr_o, base_adr(o)); end
            s_ack_i = 1'b1; #1;
            n_chk++; if (m_ack_o !== exp_g) begin n_fail++; $display("FAIL contest_ack%0d: got %b want %b", g, m_ack_o, exp_g); end
            step();
            s_ack_i = 1'b0;
            set_master(o, 1'b0, 1'b0, CTI_CLASSIC, base_adr(o));
            #2;
            n_chk++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL contest_drop%0d: s_cyc got %b want 0", g, s_cyc_o); end
            step(); #2;
            n_chk++; if (grant_o !== 3'b000) begin n_fail++; $display("FAIL contest_dead%0d: got %b want 000", g, grant_o); end
            if (g < 3) set_master(o, 1'b1, 1'b1, CTI_CLASSIC, base_adr(o));
            else idle_all();
        end
        step();
    endtask

    task automatic test_single();
        set_master(1, 1'b1, 1'b1, CTI_CLASSIC, base_adr(1));
        #2;
        n_chk++; if (grant_o !== 3'b000 || s_stb_o !== 1'b0) begin n_fail++; $display("FAIL single_c0: grant %b stb %b want 000 0", grant_o, s_stb_o); end
        step(); #2;
        n_chk++; if (grant_o !== 3'b010 || s_stb_o !== 1'b1) begin n_fail++; $display("FAIL single_c1: grant %b stb %b want 010 1", grant_o, s_stb_o); end
        step(); #2;
        n_chk++; if (m_ack_o !== 3'b000) begin n_fail++; $display("FAIL single_c2_ack: got %b want 000", m_ack_o); end
        step();
        s_ack_i = 1'b1; #1;
        n_chk++; if (m_ack_o !== 3'b010 || m_dat_o !== 32'hdead_beef) begin n_fail++; $display("FAIL single_c3_ack: ack %b dat %h want 010 deadbeef", m_ack_o, m_dat_o); end
        step();
        idle_all();
        step(); #2;
        n_chk++; if (grant_o !== 3'b000) begin n_fail++; $display("FAIL single_release: got %b want 000", grant_o); end
    endtask

    task automatic test_burst_hold();
        logic [NM-1:0] exp_g;
        set_master(2, 1'b1, 1'b1, CTI_INCR, base_adr(2));
        exp_q.push_back(3'b100);
        step(); #2;
        exp_g = exp_q.pop_front();
        n_chk++; if (grant_o !== exp_g) begin n_fail++; $display("FAIL burst_grant: got %b want %b", grant_o, exp_g); end
        set_master(0, 1'b1, 1'b1, CTI_CLASSIC, base_adr(0));
        for (int b = 0; b < 8; b++) begin
            set_master(2, 1'b1, 1'b1, (b == 7) ? CTI_EOB : CTI_INCR, base_adr(2) + 32'(4 * b));
            adr_q.push_back(base_adr(2) + 32'(4 * b));
            s_ack_i = 1'b1; #1;
            n_chk++; if (s_adr_o !== adr_q.pop_front() || grant_o !== 3'b100) begin n_fail++; $display("FAIL burst_beat%0d: adr %h grant %b", b, s_adr_o, grant_o); end
            n_chk++; if (m_ack_o !== 3'b100) begin n_fail++; $display("FAIL burst_ack%0d: got %b want 100", b, m_ack_o); end
            step();
        end
        s_ack_i = 1'b0;
        set_master(2, 1'b0, 1'b0, CTI_CLASSIC, base_adr(2));
        exp_q.push_back(3'b001);
        step(); #2;
        n_chk++; if (grant_o !== 3'b000) begin n_fail++; $display("FAIL burst_dead: got %b want 000", grant_o); end
        step(); #2;
        exp_g = exp_q.pop_front();
        n_chk++; if (grant_o !== exp_g) begin n_fail++; $display("FAIL burst_next: got %b want %b", grant_o, exp_g); end
        idle_all();
        step(); step();
    endtask

    task automatic test_timeout();
        set_master(1, 1'b1, 1'b1, CTI_CLASSIC, base_adr(1));
        step(); #2;
        n_chk++; if (s_stb_o !== 1'b1) begin n_fail++; $display("FAIL timeout_stb: got %b want 1", s_stb_o); end
        for (int k = 2; k <= 4; k++) begin
            step(); #2;
            n_chk++; if (m_err_o !== 3'b000) begin n_fail++; $display("FAIL timeout_early%0d: got %b want 000", k, m_err_o); end
        end
        step(); #2;
        n_chk++; if (m_err_o !== 3'b010 || m_ack_o !== 3'b000) begin n_fail++; $display("FAIL timeout_err: err %b ack %b want 010 000", m_err_o, m_ack_o); end
        step();
        idle_all();
        #2;
        n_chk++; if (s_cyc_o !== 1'b0 || grant_o !== 3'b000 || state_o !== ST_IDLE) begin n_fail++; $display("FAIL timeout_idle: cyc %b grant %b state %0d want 0 000 IDLE", s_cyc_o, grant_o, state_o); end
        step();
    endtask

    task automatic test_error();
        set_master(0, 1'b1, 1'b1, CTI_CLASSIC, base_adr(0));
        step(); #2;
        n_chk++; if (grant_o !== 3'b001) begin n_fail++; $display("FAIL err_grant: got %b want 001", grant_o); end
        s_err_i = 1'b1; #1;
        n_chk++; if (m_err_o !== 3'b001 || m_ack_o !== 3'b000 || m_rty_o !== 3'b000) begin n_fail++; $display("FAIL err_pass: err %b ack %b rty %b want 001 000 000", m_err_o, m_ack_o, m_rty_o); end
        step();
        s_err_i = 1'b0;
        m_stb[0] = 1'b0;
        s_ack_i = 1'b1; #1;
        n_chk++; if (m_ack_o !== 3'b000 || m_err_o !== 3'b000) begin n_fail++; $display("FAIL err_stray_ack: ack %b err %b want 000 000", m_ack_o, m_err_o); end
        step();
        idle_all();
        step(); step();
    endtask

    task automatic test_reset_mid_burst();
        logic [NM-1:0] exp_g;
        set_master(1, 1'b1, 1'b1, CTI_INCR, base_adr(1));
        step(); #2;
        n_chk++; if (grant_o !== 3'b010) begin n_fail++; $display("FAIL rstb_grant: got %b want 010", grant_o); end
        for (int b = 0; b < 2; b++) begin
            set_master(1, 1'b1, 1'b1, CTI_INCR, base_adr(1) + 32'(4 * b));
            s_ack_i = 1'b1;
            step();
        end
        rst_n = 1'b0;
        step(); #2;
        n_chk++; if (s_cyc_o !== 1'b0 || grant_o !== 3'b000) begin n_fail++; $display("FAIL rstb_abort: cyc %b grant %b want 0 000", s_cyc_o, grant_o); end
        n_chk++; if (m_ack_o !== 3'b000 || m_err_o !== 3'b000) begin n_fail++; $display("FAIL rstb_noresp: ack %b err %b want 000 000", m_ack_o, m_err_o); end
        rst_n = 1'b1;
        s_ack_i = 1'b0;
        for (int m = 0; m < NM; m++) set_master(m, 1'b1, 1'b1, CTI_CLASSIC, base_adr(m));
        exp_q.push_back(3'b001);
        step(); #2;
        exp_g = exp_q.pop_front();
        n_chk++; if (grant_o !== exp_g) begin n_fail++; $display("FAIL rstb_contest: got %b want %b", grant_o, exp_g); end
        idle_all();
        step(); step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_contest();
        test_single();
        test_burst_hold();
        test_timeout();
        test_error();
        test_reset_mid_burst();
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: %0d entries want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100000");
        $fatal(1, "bench timeout");
    end

endmodule
